// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit path: arbiter state
// encoding, baud divider and the default acceptance timeout.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XMIT,
    DRAIN
  } state_t;

  localparam int BAUD_DIV        = 10417;
  localparam int TIMEOUT_DEFAULT = 31250;

  // Position 'off' steps after 'base' in a ring of n entries.
  function automatic int rr_index(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after ptr,
// wrapping modulo N.
module rr_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[rr_index(int'(ptr), k, N)]) begin
        any                           = 1'b1;
        idx                           = ID_W'(rr_index(int'(ptr), k, N));
        grant[rr_index(int'(ptr), k, N)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers; each producer
// owns a one-byte holding slot, slots are served round-robin one frame at a time.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_send,
  output logic [7:0]           uart_data,
  input  logic [3:0]           uart_send_sta,
  input  logic                 uart_send_done,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t               state;
  logic [NUM_REQ-1:0]   hold_valid;
  logic [7:0]           hold_data [NUM_REQ];
  logic [ID_W-1:0]      ptr;
  logic [CNT_W-1:0]     cnt;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [ID_W-1:0]      arb_idx;
  logic                 arb_any;

  assign req_ready = ~hold_valid;
  assign busy      = (state != IDLE);

  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req   (hold_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // NOTE: slot bytes carry no reset; they are only ever read while hold_valid is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && !hold_valid[i]) hold_data[i] <= req_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      hold_valid  <= '0;
      ptr         <= '0;
      cnt         <= '0;
      uart_send   <= 1'b0;
      uart_data   <= '0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
    end else begin
      // NOTE: non-blocking updates; a load and the accept-clear never target the same full slot.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && !hold_valid[i]) hold_valid[i] <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (arb_any) begin
            grant_id  <= arb_idx;
            uart_data <= hold_data[arb_idx];
            uart_send <= 1'b1;
            cnt       <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (uart_send_sta != 4'd0) begin
            uart_send            <= 1'b0;
            hold_valid[grant_id] <= 1'b0;
            ptr   <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            state <= XMIT;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            // Slot and pointer are untouched so the same port is retried.
            uart_send   <= 1'b0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        XMIT: begin
          if (uart_send_done) state <= DRAIN;
        end
        DRAIN: begin
          if (uart_send_sta == 4'd0 && !uart_send_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
